// File: rtl/toggle_dec_pkg.sv
// Shared definitions for the toggle pulse decoder: FSM state type and
// default parameter values.
package toggle_dec_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 4;

  // Wide enough for the priming count (SYNC_STAGES is at most 4)
  localparam int PRIME_CNT_W     = 3;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } dec_state_e;

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops, cleared asynchronously
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_pulse_decoder.sv
// Toggle-encoded event decoder: synchronizes tog_in, turns each level change
// into a one-cycle event_pulse and counts unconsumed events in a saturating
// pending counter drained by a valid/ready consumer.
// Optional sticky overflow flag is built only when TOGGLE_DEC_OVF_EN is defined.
//
// state | meaning
// PRIME | loading prev from the synchronizer after reset; events suppressed
// RUN   | comparing synchronizer output against prev; events decoded
module toggle_pulse_decoder
  import toggle_dec_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             tog_in,
  output logic             event_pulse,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [PRIME_CNT_W-1:0] PRIME_START = PRIME_CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]       PEND_MAX    = '1;

  dec_state_e             state_q, state_d;
  logic [PRIME_CNT_W-1:0] prime_cnt_q, prime_cnt_d;
  logic                   prev_q, prev_d;
  logic                   event_pulse_q, event_pulse_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   sync_out;
  logic                   event_det;
  logic                   accept;
  logic                   ovf_set;

  toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (tog_in),
    .q       (sync_out)
  );

  // State, priming timer and decode registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= PRIME;
      prime_cnt_q   <= PRIME_START;
      prev_q        <= 1'b0;
      event_pulse_q <= 1'b0;
      pending_q     <= '0;
    end else begin
      state_q       <= state_d;
      prime_cnt_q   <= prime_cnt_d;
      prev_q        <= prev_d;
      event_pulse_q <= event_pulse_d;
      pending_q     <= pending_d;
    end
  end

  // Next state: hold in PRIME until the down-counter reaches terminal count
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    case (state_q)
      PRIME: begin
        if (prime_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          prime_cnt_d = prime_cnt_q - PRIME_CNT_W'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
  end

  // FSM outputs: event detection is gated off while priming; prev always tracks
  always_comb begin
    prev_d        = sync_out;
    event_det     = (state_q == RUN) && (sync_out != prev_q);
    event_pulse_d = event_det;
  end

  // Pending counter: saturates at all-ones, an event plus acceptance cancel out
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    accept    = ev_valid && ev_ready;
    if (event_det && !accept) begin
      if (pending_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end else if (!event_det && accept) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  assign event_pulse = event_pulse_q;
  assign pending     = pending_q;
  assign ev_valid    = (pending_q != '0);

`ifdef TOGGLE_DEC_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a new overflow wins over a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic [1:0] unused_ovf_sigs;
  assign unused_ovf_sigs = {ovf_clr, ovf_set};
  assign ovf             = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Self-checking bench for toggle_pulse_decoder (SYNC_STAGES=2, CNT_W=4).
module tb_toggle_pulse_decoder;

  localparam int SS   = 2;
  localparam int CW   = 4;
  localparam int PMAX = 15;
`ifdef TOGGLE_DEC_OVF_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  logic          clk      = 1'b0;
  logic          clear_n  = 1'b1;
  logic          tog_in   = 1'b0;
  logic          ev_ready = 1'b0;
  logic          ovf_clr  = 1'b0;
  logic          event_pulse;
  logic          ev_valid;
  logic          ovf;
  logic [CW-1:0] pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  toggle_pulse_decoder #(
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .tog_in      (tog_in),
    .event_pulse (event_pulse),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .pending     (pending),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: tog_hist[k] is tog_in as seen at the k-th rising edge
  // since reset release. An event is reported at edge k when the level seen
  // SS edges earlier differs from the one before it, provided both samples
  // were taken late enough for the post-reset priming to have absorbed them.
  bit tog_hist [0:8191];
  int k         = 0;
  bit pulse_exp = 1'b0;
  int pend_exp  = 0;
  bit ovf_exp   = 1'b0;

  always @(posedge clk or negedge clear_n) begin
    bit ev, acc, sat;
    if (!clear_n) begin
      k         = 0;
      pulse_exp = 1'b0;
      pend_exp  = 0;
      ovf_exp   = 1'b0;
    end else begin
      if (k < 8191) k++;
      tog_hist[k] = tog_in;
      ev  = (k >= SS + 2) && (tog_hist[k-SS] != tog_hist[k-SS-1]);
      acc = ev_ready && (pend_exp > 0);
      sat = ev && !acc && (pend_exp == PMAX);
      pulse_exp = ev;
      if (ev && !acc && !sat) pend_exp++;
      else if (acc && !ev)    pend_exp--;
      if (OVF_EN != 0 && sat) ovf_exp = 1'b1;
      else if (ovf_clr)       ovf_exp = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("cyc_pulse",    int'(event_pulse), int'(pulse_exp));
    check("cyc_pending",  int'(pending),     pend_exp);
    check("cyc_ev_valid", int'(ev_valid),    (pend_exp != 0) ? 1 : 0);
    check("cyc_ovf",      int'(ovf),         int'(ovf_exp));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with tog_in held high, then stay static
    tog_in = 1'b1;
    #1 clear_n = 1'b0;
    cyc(2);
    check("rst_pending",  int'(pending),     0);
    check("rst_ev_valid", int'(ev_valid),    0);
    check("rst_pulse",    int'(event_pulse), 0);
    check("rst_ovf",      int'(ovf),         0);
    clear_n = 1'b1;
    cyc(10);
    check("static1_pending",  int'(pending),  0);
    check("static1_ev_valid", int'(ev_valid), 0);

    // Reset with tog_in low, then a single 0->1 change with exact latency
    tog_in  = 1'b0;
    clear_n = 1'b0;
    cyc(2);
    clear_n = 1'b1;
    cyc(8);
    check("static0_pending", int'(pending), 0);
    tog_in = 1'b1;
    cyc(1); check("lat_e0_pulse", int'(event_pulse), 0);
    cyc(1); check("lat_e1_pulse", int'(event_pulse), 0);
    cyc(1); check("lat_e2_pulse", int'(event_pulse), 1);
            check("lat_pending",  int'(pending),     1);
            check("lat_ev_valid", int'(ev_valid),    1);
    cyc(1); check("lat_e3_pulse", int'(event_pulse), 0);
    ev_ready = 1'b1;
    cyc(1);
    ev_ready = 1'b0;
    check("acc_pending",  int'(pending),  0);
    check("acc_ev_valid", int'(ev_valid), 0);

    // Ready with nothing pending must not underflow
    ev_ready = 1'b1;
    cyc(3);
    ev_ready = 1'b0;
    check("idle_ready_pending", int'(pending), 0);

    // Fill to saturation, then one more
    for (int i = 0; i < 15; i++) begin
      tog_in = ~tog_in;
      cyc(4);
    end
    check("fill_pending", int'(pending), 15);
    check("fill_ovf",     int'(ovf),     0);
    check("model_fill",   pend_exp,      15);
    tog_in = ~tog_in;
    cyc(4);
    check("sat_pending", int'(pending), 15);
    check("sat_ovf",     int'(ovf),     OVF_EN);

    // ovf_clr on the same edge as a saturating event, then alone
    tog_in = ~tog_in;
    cyc(2);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("clr_coincident_ovf",   int'(ovf),     OVF_EN);
    check("clr_coincident_pend",  int'(pending), 15);
    check("model_clr_coincident", int'(ovf_exp), OVF_EN);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("clr_alone_ovf", int'(ovf), 0);

    // Drain to 3, then event and acceptance on the same edge
    ev_ready = 1'b1;
    cyc(12);
    ev_ready = 1'b0;
    check("drain_pending", int'(pending), 3);
    tog_in = ~tog_in;
    cyc(2);
    ev_ready = 1'b1;
    cyc(1);
    ev_ready = 1'b0;
    check("both_pulse",   int'(event_pulse), 1);
    check("both_pending", int'(pending),     3);

    // Overflow again, drain to 5, then reset mid-cycle with a toggle in flight
    for (int i = 0; i < 13; i++) begin
      tog_in = ~tog_in;
      cyc(4);
    end
    check("refill_pending", int'(pending), 15);
    check("refill_ovf",     int'(ovf),     OVF_EN);
    ev_ready = 1'b1;
    cyc(10);
    ev_ready = 1'b0;
    check("five_pending", int'(pending), 5);
    check("model_five",   pend_exp,      5);
    tog_in = ~tog_in;
    cyc(1);
    @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    check("async_pending",  int'(pending),     0);
    check("async_ev_valid", int'(ev_valid),    0);
    check("async_ovf",      int'(ovf),         0);
    check("async_pulse",    int'(event_pulse), 0);
    cyc(2);
    clear_n = 1'b1;
    cyc(12);
    check("post_rst_pending", int'(pending),  0);
    check("post_rst_valid",   int'(ev_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
